// File: rtl/pid_input_scheduler_if.sv
// Stream bundle between the PID input scheduler (master) and the PID core (slave):
// coefficient broadcast plus the feedback/reference sample channel with its ready.
interface pid_input_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHN_WIDTH  = 3
);
  logic                  param_valid;
  logic [CHN_WIDTH-1:0]  param_chn;
  logic [DATA_WIDTH-1:0] param_a1;
  logic [DATA_WIDTH-1:0] param_a2;
  logic [DATA_WIDTH-1:0] param_a3;
  logic [DATA_WIDTH-1:0] param_b0;
  logic [DATA_WIDTH-1:0] param_b1;
  logic [DATA_WIDTH-1:0] param_b2;
  logic [DATA_WIDTH-1:0] param_max;
  logic [DATA_WIDTH-1:0] param_min;

  logic                  data_valid;
  logic [CHN_WIDTH-1:0]  data_chn;
  logic [DATA_WIDTH-1:0] data_fdb;
  logic [DATA_WIDTH-1:0] data_ref;
  logic                  tready;

  modport master (
    output param_valid, param_chn, param_a1, param_a2, param_a3,
           param_b0, param_b1, param_b2, param_max, param_min,
    output data_valid, data_chn, data_fdb, data_ref,
    input  tready
  );

  modport slave (
    input  param_valid, param_chn, param_a1, param_a2, param_a3,
           param_b0, param_b1, param_b2, param_max, param_min,
    input  data_valid, data_chn, data_fdb, data_ref,
    output tready
  );
endinterface

// File: rtl/pid_input_scheduler.sv
// Front end for the time-multiplexed PID core: holds measurements, saturated targets and
// coefficient sets; broadcasts coefficients, then streams one coherent round per period.
module pid_input_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CHN    = 4,
  parameter int unsigned CHN_WIDTH  = 3,
  parameter int unsigned PERIOD     = 1000,
  parameter int unsigned RPM_MAX    = 1500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHN-1:0]            rpm_valid_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
  input  logic                          tr_valid_i,
  input  logic [CHN_WIDTH-1:0]          tr_chn_i,
  input  logic [DATA_WIDTH-1:0]         tr_data_i,
  input  logic                          cfg_we_i,
  input  logic [CHN_WIDTH-1:0]          cfg_chn_i,
  input  logic [2:0]                    cfg_addr_i,
  input  logic [DATA_WIDTH-1:0]         cfg_data_i,
  input  logic                          cfg_apply_i,
  output logic                          busy_o,
  output logic                          overrun_o,
  pid_input_scheduler_if.master         pid_if
);

  typedef enum logic [1:0] {ST_PARAM, ST_WAIT, ST_FEED} state_t;

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0]            LAST_CNT = CNT_W'(PERIOD - 1);
  localparam logic [CHN_WIDTH-1:0]        LAST_CHN = CHN_WIDTH'(NUM_CHN - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_HI  = DATA_WIDTH'(RPM_MAX);
  localparam logic signed [DATA_WIDTH-1:0] SAT_LO  = -SAT_HI;

  function automatic logic [DATA_WIDTH-1:0] coef_init(input int unsigned a);
    case (a)
      0:       coef_init = DATA_WIDTH'(128);
      1:       coef_init = DATA_WIDTH'(64);
      2:       coef_init = DATA_WIDTH'(64);
      3:       coef_init = DATA_WIDTH'(26);
      4:       coef_init = DATA_WIDTH'(13);
      5:       coef_init = DATA_WIDTH'(13);
      6:       coef_init = SAT_HI;
      default: coef_init = SAT_LO;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH-1:0] v);
    logic signed [DATA_WIDTH-1:0] s;
    s = v;
    if (s > SAT_HI)      sat = SAT_HI;
    else if (s < SAT_LO) sat = SAT_LO;
    else                 sat = v;
  endfunction

  state_t                state, state_nxt;
  logic                  snap_load;
  logic [CHN_WIDTH-1:0]  param_idx;
  logic [CNT_W-1:0]      cnt;
  logic                  timer_en;
  logic                  apply_pend;
  logic                  tick_pend;
  logic                  tick, xfer, round_end, param_last, apply_req;

  logic [DATA_WIDTH-1:0] hold     [NUM_CHN];
  logic [DATA_WIDTH-1:0] target   [NUM_CHN];
  logic [DATA_WIDTH-1:0] snap_fdb [NUM_CHN];
  logic [DATA_WIDTH-1:0] snap_ref [NUM_CHN];
  logic [DATA_WIDTH-1:0] coef     [NUM_CHN][8];

  logic                  param_valid_q;
  logic [CHN_WIDTH-1:0]  param_chn_q;
  logic [DATA_WIDTH-1:0] param_w_q [8];
  logic                  data_valid_q;
  logic [CHN_WIDTH-1:0]  data_chn_q;
  logic [DATA_WIDTH-1:0] data_fdb_q, data_ref_q;
  logic                  busy_q, overrun_q;

  logic [DATA_WIDTH-1:0] coef_sel [8];
  logic [CHN_WIDTH-1:0]  feed_chn;
  logic [DATA_WIDTH-1:0] fdb_sel, ref_sel;

  assign tick       = timer_en && (cnt == LAST_CNT);
  assign xfer       = data_valid_q && pid_if.tready;
  assign round_end  = (state == ST_FEED) && xfer && (data_chn_q == LAST_CHN);
  assign param_last = (state == ST_PARAM) && (param_idx == LAST_CHN);
  assign apply_req  = apply_pend || cfg_apply_i;

  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    case (state)
      ST_PARAM: if (param_last) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tick) begin
          state_nxt = ST_FEED;
          snap_load = 1'b1;
        end
      end
      ST_FEED: begin
        if (round_end) begin
          if (apply_req)              state_nxt = ST_PARAM;
          else if (tick_pend || tick) snap_load = 1'b1;
          else                        state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_PARAM;
    endcase
  end

  // A fresh round (or the first sample after a re-snapshot) always starts at channel 0.
  always_comb begin
    feed_chn = data_valid_q ? data_chn_q + CHN_WIDTH'(1) : '0;
    fdb_sel  = '0;
    ref_sel  = '0;
    for (int unsigned a = 0; a < 8; a++) coef_sel[a] = '0;
    for (int unsigned k = 0; k < NUM_CHN; k++) begin
      if (32'(feed_chn) == k) begin
        fdb_sel = snap_fdb[k];
        ref_sel = snap_ref[k];
      end
      if (32'(param_idx) == k) begin
        for (int unsigned a = 0; a < 8; a++) coef_sel[a] = coef[k][a];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_PARAM;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      param_idx     <= '0;
      cnt           <= '0;
      timer_en      <= 1'b0;
      apply_pend    <= 1'b0;
      tick_pend     <= 1'b0;
      param_valid_q <= 1'b0;
      param_chn_q   <= '0;
      data_valid_q  <= 1'b0;
      data_chn_q    <= '0;
      data_fdb_q    <= '0;
      data_ref_q    <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int unsigned a = 0; a < 8; a++) param_w_q[a] <= '0;
      for (int unsigned k = 0; k < NUM_CHN; k++) begin
        hold[k]     <= '0;
        target[k]   <= '0;
        snap_fdb[k] <= '0;
        snap_ref[k] <= '0;
        for (int unsigned a = 0; a < 8; a++) coef[k][a] <= coef_init(a);
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CHN; k++) begin
        if (rpm_valid_i[k]) hold[k] <= rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        if (tr_valid_i && (32'(tr_chn_i) == k)) target[k] <= sat(tr_data_i);
        for (int unsigned a = 0; a < 8; a++) begin
          if (cfg_we_i && (32'(cfg_chn_i) == k) && (32'(cfg_addr_i) == a))
            coef[k][a] <= cfg_data_i;
        end
        if (snap_load) begin
          snap_fdb[k] <= hold[k];
          snap_ref[k] <= target[k];
        end
      end

      // Timer is idle until the first broadcast finishes, then free-runs.
      if (param_last && !timer_en) begin
        timer_en <= 1'b1;
        cnt      <= '0;
      end else if (timer_en) begin
        cnt <= tick ? '0 : cnt + CNT_W'(1);
      end

      if (cfg_apply_i)     apply_pend <= 1'b1;
      else if (param_last) apply_pend <= 1'b0;

      if (round_end)                         tick_pend <= 1'b0;
      else if ((state == ST_FEED) && tick)   tick_pend <= 1'b1;
      if ((state == ST_FEED) && tick && !round_end) overrun_q <= 1'b1;

      if (state == ST_PARAM) begin
        param_valid_q <= 1'b1;
        param_chn_q   <= param_idx;
        for (int unsigned a = 0; a < 8; a++) param_w_q[a] <= coef_sel[a];
        param_idx     <= param_last ? '0 : param_idx + CHN_WIDTH'(1);
      end else begin
        param_valid_q <= 1'b0;
      end

      if (state == ST_FEED) begin
        if (round_end) begin
          data_valid_q <= 1'b0;
        end else if (!data_valid_q || xfer) begin
          data_valid_q <= 1'b1;
          data_chn_q   <= feed_chn;
          data_fdb_q   <= fdb_sel;
          data_ref_q   <= ref_sel;
        end
      end else begin
        data_valid_q <= 1'b0;
      end

      busy_q <= (state_nxt != ST_WAIT);
    end
  end

  assign pid_if.param_valid = param_valid_q;
  assign pid_if.param_chn   = param_chn_q;
  assign pid_if.param_a1    = param_w_q[0];
  assign pid_if.param_a2    = param_w_q[1];
  assign pid_if.param_a3    = param_w_q[2];
  assign pid_if.param_b0    = param_w_q[3];
  assign pid_if.param_b1    = param_w_q[4];
  assign pid_if.param_b2    = param_w_q[5];
  assign pid_if.param_max   = param_w_q[6];
  assign pid_if.param_min   = param_w_q[7];
  assign pid_if.data_valid  = data_valid_q;
  assign pid_if.data_chn    = data_chn_q;
  assign pid_if.data_fdb    = data_fdb_q;
  assign pid_if.data_ref    = data_ref_q;
  assign busy_o             = busy_q;
  assign overrun_o          = overrun_q;

endmodule

// File: tb/tb_pid_input_scheduler.sv
// Directed bench for pid_input_scheduler: broadcast, rounds, saturation, stalls,
// deferred re-broadcast, overrun and mid-round reset.
module tb_pid_input_scheduler;
  localparam int unsigned DW   = 16;
  localparam int unsigned NC   = 4;
  localparam int unsigned CW   = 3;
  localparam int unsigned PER  = 12;
  localparam int unsigned RMAX = 1500;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     rpm_valid_i = '0;
  logic [NC*DW-1:0]  rpm_data_i  = '0;
  logic              tr_valid_i  = 1'b0;
  logic [CW-1:0]     tr_chn_i    = '0;
  logic [DW-1:0]     tr_data_i   = '0;
  logic              cfg_we_i    = 1'b0;
  logic [CW-1:0]     cfg_chn_i   = '0;
  logic [2:0]        cfg_addr_i  = '0;
  logic [DW-1:0]     cfg_data_i  = '0;
  logic              cfg_apply_i = 1'b0;
  logic              busy_o, overrun_o;

  pid_input_scheduler_if #(.DATA_WIDTH(DW), .CHN_WIDTH(CW)) pif ();

  pid_input_scheduler #(
    .DATA_WIDTH(DW), .NUM_CHN(NC), .CHN_WIDTH(CW), .PERIOD(PER), .RPM_MAX(RMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .rpm_valid_i(rpm_valid_i), .rpm_data_i(rpm_data_i),
    .tr_valid_i(tr_valid_i), .tr_chn_i(tr_chn_i), .tr_data_i(tr_data_i),
    .cfg_we_i(cfg_we_i), .cfg_chn_i(cfg_chn_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_apply_i(cfg_apply_i),
    .busy_o(busy_o), .overrun_o(overrun_o),
    .pid_if(pif)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [CW-1:0] s_chn;
  logic [DW-1:0] s_fdb, s_ref;
  int unsigned   s_cyc;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at a negedge; captures the next accepted sample and returns one negedge later.
  task automatic get_sample(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (pif.data_valid && pif.tready) begin
        found = 1'b1;
        s_chn = pif.data_chn;
        s_fdb = pif.data_fdb;
        s_ref = pif.data_ref;
        s_cyc = cyc;
      end
      @(negedge clk);
    end
    check(tag, 16'(found), 16'd1);
  endtask

  task automatic tr_write(input logic [CW-1:0] c, input logic [DW-1:0] d);
    tr_valid_i = 1'b1; tr_chn_i = c; tr_data_i = d;
    @(negedge clk);
    tr_valid_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [CW-1:0] c, input logic [2:0] a, input logic [DW-1:0] d);
    cfg_we_i = 1'b1; cfg_chn_i = c; cfg_addr_i = a; cfg_data_i = d;
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  int unsigned prev_cyc, end_cyc, p_start;
  logic        found;

  initial begin
    pif.tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_param_valid", 16'(pif.param_valid), 16'd0);
    check("rst_data_valid",  16'(pif.data_valid),  16'd0);
    check("rst_busy",        16'(busy_o),          16'd0);
    check("rst_overrun",     16'(overrun_o),       16'd0);
    rst = 1'b0;

    // Initial broadcast: four consecutive cycles, channels in order
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bcast0_valid", 16'(pif.param_valid), 16'd1);
      check("bcast0_chn",   16'(pif.param_chn),   16'(k));
      if (k == 0) begin
        check("bcast0_a1",   pif.param_a1, 16'd128);
        check("bcast0_b0",   pif.param_b0, 16'd26);
        check("bcast0_busy", 16'(busy_o),  16'd1);
      end
      if (k == 3) begin
        check("bcast0_max", pif.param_max, 16'd1500);
        check("bcast0_min", pif.param_min, 16'hFA24);
      end
    end
    @(negedge clk);
    check("bcast0_end", 16'(pif.param_valid), 16'd0);

    // Load holds and targets
    rpm_valid_i = 4'hF;
    rpm_data_i  = {16'd400, 16'd300, 16'd200, 16'd100};
    @(negedge clk);
    rpm_valid_i = '0;
    for (int k = 0; k < 4; k++) tr_write(CW'(k), 16'(10 * (k + 1)));

    // Round 1: four back-to-back samples
    for (int k = 0; k < 4; k++) begin
      get_sample("r1_timeout");
      check("r1_chn", 16'(s_chn), 16'(k));
      check("r1_fdb", s_fdb, 16'(100 * (k + 1)));
      check("r1_ref", s_ref, 16'(10 * (k + 1)));
      if (k > 0) check("r1_b2b", 16'(s_cyc - prev_cyc), 16'd1);
      prev_cyc = s_cyc;
    end
    check("r1_valid_drop", 16'(pif.data_valid), 16'd0);

    // Target saturation and out-of-range channel
    tr_write(3'd1, 16'd3000);
    tr_write(3'd3, 16'hF830);
    tr_write(3'd5, 16'd77);

    // Round 2 with a 3-cycle stall on ch2
    get_sample("r2_timeout");
    check("r2_ref0", s_ref, 16'd10);
    get_sample("r2_timeout");
    check("r2_ref1_sat_hi", s_ref, 16'd1500);
    check("r2_ch2_presented", 16'(pif.data_chn), 16'd2);
    pif.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_chn", 16'(pif.data_chn), 16'd2);
      check("stall_fdb", pif.data_fdb, 16'd300);
      check("stall_ref", pif.data_ref, 16'd30);
    end
    pif.tready = 1'b1;
    get_sample("r2_timeout");
    check("r2_ch2", 16'(s_chn), 16'd2);
    prev_cyc = s_cyc;
    get_sample("r2_timeout");
    check("r2_ch3", 16'(s_chn), 16'd3);
    check("r2_ref3_sat_lo", s_ref, 16'hFA24);
    check("r2_after_stall", 16'(s_cyc - prev_cyc), 16'd1);

    // Coefficient write then apply request mid-round
    cfg_write(3'd2, 3'd0, 16'd200);
    cfg_write(3'd5, 3'd0, 16'd999);
    get_sample("r3_timeout");
    check("r3_ch0", 16'(s_chn), 16'd0);
    cfg_apply_i = 1'b1;
    @(negedge clk);
    cfg_apply_i = 1'b0;
    get_sample("r3_timeout");
    get_sample("r3_timeout");
    check("r3_ch3", 16'(s_chn), 16'd3);
    end_cyc = s_cyc;

    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      if (pif.param_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("bcast1_seen", 16'(found), 16'd1);
    p_start = cyc;
    check("bcast1_after_round", 16'(p_start > end_cyc), 16'd1);
    for (int k = 0; k < 4; k++) begin
      check("bcast1_chn", 16'(pif.param_chn), 16'(k));
      check("bcast1_a1", pif.param_a1, (k == 2) ? 16'd200 : 16'd128);
      if (k < 3) @(negedge clk);
    end
    @(negedge clk);
    check("bcast1_end", 16'(pif.param_valid), 16'd0);
    check("no_overrun_yet", 16'(overrun_o), 16'd0);

    // Overrun: hold tready low well past one period
    pif.tready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pif.data_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("ovr_round_seen", 16'(found), 16'd1);
    repeat (15) @(negedge clk);
    check("ovr_chn_held", 16'(pif.data_chn), 16'd0);
    check("ovr_flag",     16'(overrun_o),    16'd1);
    check("ovr_busy",     16'(busy_o),       16'd1);
    pif.tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      get_sample("ovr_timeout");
      check("ovr_chn", 16'(s_chn), 16'(k));
    end
    prev_cyc = s_cyc;
    get_sample("ovr_next_timeout");
    check("ovr_next_chn",   16'(s_chn), 16'd0);
    check("ovr_next_fdb",   s_fdb, 16'd100);
    check("ovr_next_start", 16'(s_cyc - prev_cyc), 16'd2);
    check("ovr_sticky",     16'(overrun_o), 16'd1);

    // Reset mid-round
    rst = 1'b1;
    @(negedge clk);
    check("rst2_data_valid",  16'(pif.data_valid),  16'd0);
    check("rst2_param_valid", 16'(pif.param_valid), 16'd0);
    check("rst2_overrun",     16'(overrun_o),       16'd0);
    check("rst2_busy",        16'(busy_o),          16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_bcast_valid", 16'(pif.param_valid), 16'd1);
    check("rst2_bcast_chn",   16'(pif.param_chn),   16'd0);
    check("rst2_bcast_a1",    pif.param_a1,         16'd128);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
